// File: rtl/uart_cmd_parser_if.sv
// rtl/uart_cmd_parser_if.sv - byte handshake between uart_cmd_parser and the UART core
interface uart_cmd_parser_if;
  logic [7:0] rx_data;
  logic       rxrdy;
  logic       parity_err;
  logic       framing_err;
  logic       overflow;
  logic       oen;
  logic [7:0] tx_data;
  logic       wen;
  logic       txrdy;

  // parser side
  modport master (
    input  rx_data, rxrdy, parity_err, framing_err, overflow, txrdy,
    output oen, tx_data, wen
  );

  // UART core side
  modport slave (
    output rx_data, rxrdy, parity_err, framing_err, overflow, txrdy,
    input  oen, tx_data, wen
  );
endinterface

// File: rtl/uart_cmd_parser.sv
// rtl/uart_cmd_parser.sv - 5-byte command frame parser with register bank (option: UART_CMD_STATUS_EN)
module uart_cmd_parser #(
  parameter int NUM_REGS       = 4,
  parameter logic [7:0] SYNC_BYTE = 8'hA5,
  parameter int TIMEOUT_CYCLES = 100000,
  parameter int ERR_W          = 8
) (
  input  logic               clk,
  input  logic               rst,
  uart_cmd_parser_if.master  uart,
  output logic [3:0]         led,
  output logic [ERR_W-1:0]   err_cnt,
  output logic               frame_ok
);

  localparam logic [7:0] CMD_W = 8'h57;
  localparam logic [7:0] CMD_R = 8'h52;
`ifdef UART_CMD_STATUS_EN
  localparam logic [7:0] CMD_S = 8'h53;
`endif
  localparam logic [7:0] ACK   = 8'h06;
  localparam logic [7:0] NAK   = 8'h15;
  localparam int AW = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1;
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

  typedef enum logic [3:0] {
    HUNT, GET_CMD, GET_ADDR, GET_DATA, GET_CHK, RX_WAIT, EXEC, TX, TX_GAP
  } state_t;

  state_t          state;
  state_t          rx_next;
  logic [7:0]      cmd, addr, data, chk;
  logic [7:0]      regs [NUM_REGS];
  logic [TW-1:0]   tmo_cnt;
  logic [7:0]      tx_q0, tx_q1;
  logic            tx_more;
  logic            gap;
`ifdef UART_CMD_STATUS_EN
  logic            ovf_seen, par_seen, frm_seen;
`endif

  logic rx_err;
  logic chk_ok;
  logic addr_ok;

  assign rx_err  = uart.parity_err | uart.framing_err | uart.overflow;
  assign chk_ok  = (chk == (cmd ^ addr ^ data));
  assign addr_ok = ({1'b0, addr} < 9'(NUM_REGS));
  assign led     = regs[0][3:0];

  function automatic logic [ERR_W-1:0] sat_inc(input logic [ERR_W-1:0] v);
    return (v == '1) ? v : v + 1'b1;
  endfunction

  // Frame FSM: byte pop, frame classification, register access and response transmit
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state        <= HUNT;
      rx_next      <= HUNT;
      cmd          <= '0;
      addr         <= '0;
      data         <= '0;
      chk          <= '0;
      tmo_cnt      <= '0;
      tx_q0        <= '0;
      tx_q1        <= '0;
      tx_more      <= 1'b0;
      gap          <= 1'b0;
      uart.oen     <= 1'b1;
      uart.wen     <= 1'b1;
      uart.tx_data <= '0;
      err_cnt      <= '0;
      frame_ok     <= 1'b0;
      for (int i = 0; i < NUM_REGS; i++) regs[i] <= '0;
`ifdef UART_CMD_STATUS_EN
      ovf_seen     <= 1'b0;
      par_seen     <= 1'b0;
      frm_seen     <= 1'b0;
`endif
    end else begin
      uart.oen <= 1'b1;
      uart.wen <= 1'b1;
      frame_ok <= 1'b0;
      case (state)
        HUNT: begin
          if (uart.rxrdy) begin
            uart.oen <= 1'b0;
            tmo_cnt  <= '0;
            state    <= RX_WAIT;
            rx_next  <= (uart.rx_data == SYNC_BYTE) ? GET_CMD : HUNT;
`ifdef UART_CMD_STATUS_EN
            ovf_seen <= ovf_seen | uart.overflow;
            par_seen <= par_seen | uart.parity_err;
            frm_seen <= frm_seen | uart.framing_err;
`endif
          end
        end
        GET_CMD, GET_ADDR, GET_DATA, GET_CHK: begin
          if (uart.rxrdy) begin
            uart.oen <= 1'b0;
            tmo_cnt  <= '0;
            state    <= RX_WAIT;
`ifdef UART_CMD_STATUS_EN
            ovf_seen <= ovf_seen | uart.overflow;
            par_seen <= par_seen | uart.parity_err;
            frm_seen <= frm_seen | uart.framing_err;
`endif
            if (rx_err) begin
              rx_next <= HUNT;
              err_cnt <= sat_inc(err_cnt);
            end else begin
              case (state)
                GET_CMD:  begin cmd  <= uart.rx_data; rx_next <= GET_ADDR; end
                GET_ADDR: begin addr <= uart.rx_data; rx_next <= GET_DATA; end
                GET_DATA: begin data <= uart.rx_data; rx_next <= GET_CHK;  end
                default:  begin chk  <= uart.rx_data; rx_next <= EXEC;     end
              endcase
            end
          end else if (tmo_cnt == TW'(TIMEOUT_CYCLES - 1)) begin
            tmo_cnt <= '0;
            state   <= HUNT;
            err_cnt <= sat_inc(err_cnt);
          end else begin
            tmo_cnt <= tmo_cnt + 1'b1;
          end
        end
        RX_WAIT: begin
          if (!uart.rxrdy) state <= rx_next;
        end
        EXEC: begin
          state   <= TX;
          tx_more <= 1'b0;
          tx_q0   <= ACK;
          if (chk_ok && cmd == CMD_W && addr_ok) begin
            regs[addr[AW-1:0]] <= data;
            frame_ok <= 1'b1;
          end else if (chk_ok && cmd == CMD_R && addr_ok) begin
            tx_q1    <= regs[addr[AW-1:0]];
            tx_more  <= 1'b1;
            frame_ok <= 1'b1;
`ifdef UART_CMD_STATUS_EN
          end else if (chk_ok && cmd == CMD_S) begin
            tx_q1    <= {ovf_seen, par_seen, frm_seen, err_cnt[4:0]};
            tx_more  <= 1'b1;
            frame_ok <= 1'b1;
            ovf_seen <= 1'b0;
            par_seen <= 1'b0;
            frm_seen <= 1'b0;
`endif
          end else begin
            tx_q0   <= NAK;
            err_cnt <= sat_inc(err_cnt);
          end
        end
        TX: begin
          if (uart.txrdy) begin
            uart.tx_data <= tx_q0;
            uart.wen     <= 1'b0;
            gap          <= 1'b0;
            state        <= TX_GAP;
          end
        end
        TX_GAP: begin
          // two cycles where txrdy is not looked at, giving the core time to drop it
          if (!gap) begin
            gap <= 1'b1;
          end else if (tx_more) begin
            tx_q0   <= tx_q1;
            tx_more <= 1'b0;
            state   <= TX;
          end else begin
            state <= HUNT;
          end
        end
        default: state <= HUNT;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_cmd_parser.sv
// tb/tb_uart_cmd_parser.sv - randomized frame-level model bench for uart_cmd_parser
module tb_uart_cmd_parser;
  localparam int NREG = 4;
  localparam int TMO  = 64;
  localparam int EW   = 5;
  localparam int EMAX = (1 << EW) - 1;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic [3:0]    led;
  logic [EW-1:0] err_cnt;
  logic          frame_ok;

  uart_cmd_parser_if u_if();

  uart_cmd_parser #(
    .NUM_REGS(NREG), .SYNC_BYTE(8'hA5), .TIMEOUT_CYCLES(TMO), .ERR_W(EW)
  ) dut (
    .clk(clk), .rst(rst), .uart(u_if), .led(led), .err_cnt(err_cnt), .frame_ok(frame_ok)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  // reference state
  logic [7:0] mregs [NREG];
  int         merr;
  int         mok;
  logic [7:0] exp_tx [$];
  logic [7:0] tx_log [$];
  int         wen_seen;
  int         oen_seen;
  int         ok_seen;

  bit   txrdy_rand  = 1'b0;
  logic txrdy_fixed = 1'b1;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
    end
  endtask

  always @(negedge clk) u_if.txrdy <= txrdy_rand ? ($urandom_range(0, 3) != 0) : txrdy_fixed;

  // compare process: every transmitted byte must be the next one the model expects
  always @(negedge clk) begin
    if (rst && !u_if.oen) oen_seen++;
    if (rst && frame_ok) ok_seen++;
    if (rst && !u_if.wen) begin
      wen_seen++;
      tx_log.push_back(u_if.tx_data);
      total++;
      if (exp_tx.size() == 0) begin
        bad++;
        $display("FAIL tx_unexpected actual=%0h required=none", u_if.tx_data);
      end else begin
        if (u_if.tx_data !== exp_tx[0]) begin
          bad++;
          $display("FAIL tx_byte actual=%0h required=%0h", u_if.tx_data, exp_tx[0]);
        end
        void'(exp_tx.pop_front());
      end
    end
  end

  function automatic int sat(input int v);
    return (v >= EMAX) ? EMAX : v + 1;
  endfunction

  // what a complete, unbroken frame must produce
  task automatic model_frame(input logic [7:0] c, a, d, k);
    bit good = (k == (c ^ a ^ d)) && (a < NREG) && (c == 8'h57 || c == 8'h52);
    if (!good) begin
      exp_tx.push_back(8'h15);
      merr = sat(merr);
    end else if (c == 8'h57) begin
      mregs[a] = d;
      exp_tx.push_back(8'h06);
      mok++;
    end else begin
      exp_tx.push_back(8'h06);
      exp_tx.push_back(mregs[a]);
      mok++;
    end
  endtask

  task automatic send_byte(input logic [7:0] b, input logic [2:0] fl);
    bit got = 1'b0;
    u_if.rx_data     = b;
    u_if.parity_err  = fl[0];
    u_if.framing_err = fl[1];
    u_if.overflow    = fl[2];
    u_if.rxrdy       = 1'b1;
    for (int i = 0; i < 2000; i++) begin
      @(negedge clk);
      if (!u_if.oen) begin got = 1'b1; break; end
    end
    u_if.rxrdy = 1'b0;
    u_if.parity_err = 1'b0; u_if.framing_err = 1'b0; u_if.overflow = 1'b0;
    total++;
    if (!got) begin
      bad++;
      $display("FAIL pop_timeout actual=no_oen required=oen byte=%0h", b);
    end
    @(negedge clk);
  endtask

  task automatic wait_idle();
    bit done = 1'b0;
    for (int i = 0; i < 4000; i++) begin
      if (exp_tx.size() == 0) begin done = 1'b1; break; end
      @(negedge clk);
    end
    total++;
    if (!done) begin
      bad++;
      $display("FAIL tx_timeout actual=%0d_pending required=0", exp_tx.size());
      exp_tx.delete();
    end
    repeat (6) @(negedge clk);
  endtask

  // err_at: 0 = clean frame, 1..4 = that byte carries the error flags fl and aborts
  task automatic run_frame(input logic [7:0] c, a, d, k, input int err_at, input logic [2:0] fl);
    logic [7:0] fb [5];
    fb[0] = 8'hA5; fb[1] = c; fb[2] = a; fb[3] = d; fb[4] = k;
    if (err_at == 0) model_frame(c, a, d, k);
    for (int i = 0; i < 5; i++) begin
      if (err_at != 0 && i > err_at) break;
      send_byte(fb[i], (err_at != 0 && i == err_at) ? fl : 3'b000);
    end
    if (err_at != 0) merr = sat(merr);
    wait_idle();
    check("err_cnt", 32'(err_cnt), 32'(merr));
    check("led", 32'(led), 32'(mregs[0][3:0]));
    check("frame_ok_cnt", 32'(ok_seen), 32'(mok));
  endtask

  task automatic model_reset();
    for (int i = 0; i < NREG; i++) mregs[i] = 8'h00;
    merr = 0; mok = 0; ok_seen = 0;
    exp_tx.delete();
  endtask

  int w0, o0;

  initial begin
    u_if.rx_data = 8'h00; u_if.rxrdy = 1'b0;
    u_if.parity_err = 1'b0; u_if.framing_err = 1'b0; u_if.overflow = 1'b0;
    model_reset();
    wen_seen = 0; oen_seen = 0;
    repeat (3) @(negedge clk);
    check("rst_oen", 32'(u_if.oen), 32'd1);
    check("rst_wen", 32'(u_if.wen), 32'd1);
    check("rst_tx_data", 32'(u_if.tx_data), 32'd0);
    check("rst_led", 32'(led), 32'd0);
    check("rst_err_cnt", 32'(err_cnt), 32'd0);
    check("rst_frame_ok", 32'(frame_ok), 32'd0);
    rst = 1'b1;
    repeat (2) @(negedge clk);

    // 1: write 05 to reg0
    tx_log.delete();
    run_frame(8'h57, 8'h00, 8'h05, 8'h52, 0, 3'b000);
    check("t1_led", 32'(led), 32'h5);
    check("t1_err", 32'(err_cnt), 32'd0);
    check("t1_ok", 32'(ok_seen), 32'd1);
    check("t1_tx", 32'(tx_log.size() == 1 && tx_log[0] == 8'h06), 32'd1);

    // 2: read back reg0
    tx_log.delete(); w0 = wen_seen;
    run_frame(8'h52, 8'h00, 8'h00, 8'h52, 0, 3'b000);
    check("t2_wen_cnt", 32'(wen_seen - w0), 32'd2);
    check("t2_tx", 32'(tx_log.size() == 2 && tx_log[0] == 8'h06 && tx_log[1] == 8'h05), 32'd1);

    // 3: bad checksum
    tx_log.delete();
    run_frame(8'h57, 8'h01, 8'h33, 8'h00, 0, 3'b000);
    check("t3_err", 32'(err_cnt), 32'd1);
    check("t3_tx", 32'(tx_log.size() == 1 && tx_log[0] == 8'h15), 32'd1);
    tx_log.delete();
    run_frame(8'h52, 8'h01, 8'h00, 8'h53, 0, 3'b000);
    check("t3_reg1", 32'(tx_log.size() == 2 && tx_log[1] == 8'h00), 32'd1);

    // 4: parity error on the address byte aborts silently
    w0 = wen_seen;
    run_frame(8'h57, 8'h02, 8'h00, 8'h00, 2, 3'b001);
    check("t4_err", 32'(err_cnt), 32'd2);
    check("t4_no_tx", 32'(wen_seen - w0), 32'd0);
    run_frame(8'h57, 8'h02, 8'hAA, 8'hFF, 0, 3'b000);
    tx_log.delete();
    run_frame(8'h52, 8'h02, 8'h00, 8'h50, 0, 3'b000);
    check("t4_reg2", 32'(tx_log.size() == 2 && tx_log[1] == 8'hAA), 32'd1);

    // 5: inter-byte timeout
    w0 = wen_seen;
    send_byte(8'hA5, 3'b000);
    send_byte(8'h57, 3'b000);
    repeat (TMO + 40) @(negedge clk);
    merr = sat(merr);
    check("t5_err", 32'(err_cnt), 32'd3);
    check("t5_no_tx", 32'(wen_seen - w0), 32'd0);
    run_frame(8'h57, 8'h03, 8'h11, 8'h45, 0, 3'b000);

    // boundary: address NUM_REGS-1 valid, NUM_REGS rejected
    run_frame(8'h57, 8'h04, 8'h11, 8'h42, 0, 3'b000);
    check("addr_oob_err", 32'(err_cnt), 32'd4);

    // 6: transmitter stalled during ACK, with a byte waiting at the receiver
    txrdy_fixed = 1'b0;
    @(negedge clk);
    model_frame(8'h57, 8'h01, 8'h77, 8'h57 ^ 8'h01 ^ 8'h77);
    send_byte(8'hA5, 3'b000); send_byte(8'h57, 3'b000); send_byte(8'h01, 3'b000);
    send_byte(8'h77, 3'b000); send_byte(8'h57 ^ 8'h01 ^ 8'h77, 3'b000);
    w0 = wen_seen; o0 = oen_seen;
    u_if.rx_data = 8'h00; u_if.rxrdy = 1'b1;
    repeat (50) @(negedge clk);
    check("t6_stall_wen", 32'(wen_seen - w0), 32'd0);
    check("t6_stall_oen", 32'(oen_seen - o0), 32'd0);
    txrdy_fixed = 1'b1;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (oen_seen != o0) break;
    end
    u_if.rxrdy = 1'b0;
    repeat (6) @(negedge clk);
    check("t6_one_wen", 32'(wen_seen - w0), 32'd1);
    check("t6_popped", 32'(oen_seen - o0), 32'd1);

    // reset mid-frame
    send_byte(8'hA5, 3'b000); send_byte(8'h57, 3'b000);
    #3 rst = 1'b0;
    #1;
    check("t6_rst_led", 32'(led), 32'd0);
    check("t6_rst_oen", 32'(u_if.oen), 32'd1);
    check("t6_rst_wen", 32'(u_if.wen), 32'd1);
    check("t6_rst_err", 32'(err_cnt), 32'd0);
    model_reset();
    @(negedge clk);
    rst = 1'b1;
    repeat (2) @(negedge clk);

    // random traffic with line noise, stalls and error saturation
    txrdy_rand = 1'b1;
    for (int n = 0; n < 160; n++) begin
      logic [7:0] c, a, d, k, g;
      int sel, err_at;
      for (int j = $urandom_range(0, 2); j > 0; j--) begin
        g = 8'($urandom_range(0, 255));
        if (g == 8'hA5) g = 8'h5A;
        send_byte(g, 3'($urandom_range(0, 7)));
      end
      sel = $urandom_range(0, 9);
      c = (sel < 4) ? 8'h57 : (sel < 8) ? 8'h52 :
`ifdef UART_CMD_STATUS_EN
          8'($urandom_range(0, 255) & 8'hFE);
`else
          ((sel == 8) ? 8'h53 : 8'($urandom_range(0, 255)));
`endif
      if (c == 8'h53) c = 8'h53;
      a = 8'($urandom_range(0, 5));
      d = 8'($urandom_range(0, 255));
      k = ($urandom_range(0, 9) == 0) ? 8'($urandom_range(0, 255)) : (c ^ a ^ d);
      err_at = ($urandom_range(0, 9) == 0) ? $urandom_range(1, 4) : 0;
      run_frame(c, a, d, k, err_at, 3'(1 << $urandom_range(0, 2)));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #5000000;
    $display("FAIL global_timeout actual=running required=finished");
    $fatal(1);
  end
endmodule
